// File: rtl/ps2_pkg.sv
// Shared types and constants for the memory-mapped PS/2 keyboard receiver.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam int NOT_EMPTY = 0;
   localparam int OVERFLOW  = 1;
   localparam int FRAME_ERR = 2;
   localparam int COUNT_LSB = 8;

   localparam logic [63:0] DATA_ADDRESS_DEFAULT   = 64'h31000;
   localparam logic [63:0] STATUS_ADDRESS_DEFAULT = 64'h31001;

   // A frame is good when the stop bit is high and byte plus parity has odd weight.
   function automatic logic frame_ok(input logic [7:0] byte_val,
                                     input logic       parity_bit,
                                     input logic       stop_bit);
      return stop_bit & (^{byte_val, parity_bit});
   endfunction

endpackage

// File: rtl/ps2_keyboard_if.sv
// CPU bus seen by the keyboard receiver: one-cycle read/write strobes, registered read data.
interface ps2_keyboard_if;
   logic [63:0] address;
   logic        read;
   logic        write;
   logic [63:0] data_in;
   logic [63:0] data_out;

   modport master (output address, read, write, data_in, input data_out);
   modport slave  (input address, read, write, data_in, output data_out);
endinterface

// File: rtl/ps2_keyboard_byte_fifo.sv
// Byte FIFO with combinational head, wrapping pointers and an occupancy counter.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         push,
   input  logic [7:0]                   din,
   input  logic                         pop,
   output logic [7:0]                   dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [7:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: synchronizers, clock glitch filter, frame FSM,
// timeout, sticky flags and the data/status register decode.
module ps2_keyboard
   import ps2_pkg::*;
#(
   parameter logic [63:0] DATA_ADDRESS   = DATA_ADDRESS_DEFAULT,
   parameter logic [63:0] STATUS_ADDRESS = STATUS_ADDRESS_DEFAULT,
   parameter int          FIFO_DEPTH     = 16,
   parameter int          FILTER_CYCLES  = 8,
   parameter int          TIMEOUT_CYCLES = 50000
) (
   input  logic           clock,
   input  logic           reset,
   ps2_keyboard_if.slave  bus,
   input  logic           ps2_clk,
   input  logic           ps2_data
);

   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int FW = $clog2(FILTER_CYCLES+1);
   localparam int TW = $clog2(TIMEOUT_CYCLES+1);

   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;
   logic          fall;

   state_t        state, state_next;
   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          parity_bit;
   logic [TW-1:0] tmo_cnt;
   logic          timeout_hit;
   logic          push_req;
   logic          err_set;

   logic [7:0]    fifo_dout;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;
   logic          data_read, status_read, status_write, pop;
   logic          overflow, frame_err, overflow_set;
   logic [63:0]   status_word;
   logic          unused_data_in;

   always_ff @(posedge clock) begin
      if (reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // The filtered level flips only after FILTER_CYCLES consecutive samples of the new level;
   // the falling edge is flagged in the cycle that commits the flip.
   assign fall = filt_clk & ~clk_s2 & (filt_cnt == FW'(FILTER_CYCLES-1));

   always_ff @(posedge clock) begin
      if (reset) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (clk_s2 == filt_clk) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_CYCLES-1)) begin
         filt_clk <= clk_s2;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   assign timeout_hit = (state != IDLE) & ~fall & (tmo_cnt == TW'(TIMEOUT_CYCLES-1));

   always_ff @(posedge clock) begin
      if (reset || state == IDLE || fall) begin
         tmo_cnt <= '0;
      end else begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shift      <= '0;
         parity_bit <= 1'b0;
      end else begin
         state <= state_next;
         if (fall) begin
            case (state)
               IDLE:   bit_cnt <= '0;
               DATA: begin
                  shift   <= {dat_s2, shift[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: parity_bit <= dat_s2;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_next = state;
      push_req   = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE:   if (fall && !dat_s2) state_next = DATA;
         DATA:   if (fall && bit_cnt == 3'd7) state_next = PARITY;
         PARITY: if (fall) state_next = STOP;
         STOP: begin
            if (fall) begin
               state_next = IDLE;
               if (frame_ok(shift, parity_bit, dat_s2)) begin
                  push_req = 1'b1;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      if (timeout_hit) begin
         state_next = IDLE;
         err_set    = 1'b1;
      end
   end

   assign data_read    = bus.read  && (bus.address == DATA_ADDRESS);
   assign status_read  = bus.read  && (bus.address == STATUS_ADDRESS);
   assign status_write = bus.write && (bus.address == STATUS_ADDRESS);
   assign pop          = data_read & ~fifo_empty;
   assign overflow_set = push_req & fifo_full & ~pop;
   assign unused_data_in = ^{bus.data_in[63:3], bus.data_in[0]};

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_req),
      .din   (shift),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      status_word                      = '0;
      status_word[NOT_EMPTY]           = ~fifo_empty;
      status_word[OVERFLOW]            = overflow;
      status_word[FRAME_ERR]           = frame_err;
      status_word[COUNT_LSB +: 8]      = 8'(fifo_count);
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overflow  <= overflow_set | (overflow  & ~(status_write & bus.data_in[1]));
         frame_err <= err_set      | (frame_err & ~(status_write & bus.data_in[2]));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bus.data_out <= '0;
      end else if (bus.read) begin
         if (pop) begin
            bus.data_out <= {56'b0, fifo_dout};
         end else if (status_read) begin
            bus.data_out <= status_word;
         end else begin
            bus.data_out <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: a vector table for single-frame/register cases,
// plus hand sequences for overflow, timeout, clock glitches and full-FIFO pop/push.
module tb_ps2_keyboard;

   localparam int          HALF      = 40;
   localparam int          TIMEOUT   = 1000;
   localparam logic [63:0] DATA_ADDR = 64'h31000;
   localparam logic [63:0] STAT_ADDR = 64'h31001;

   logic clock = 1'b0;
   logic reset;
   logic ps2_clk;
   logic ps2_data;

   int checks   = 0;
   int failures = 0;

   ps2_keyboard_if bus_if ();

   ps2_keyboard #(
      .FIFO_DEPTH     (16),
      .FILTER_CYCLES  (8),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus_if),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data)
   );

   always #5 clock = ~clock;

   typedef enum {OP_SEND, OP_READ, OP_WRITE} op_t;

   typedef struct {
      op_t         op;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic        bad_parity;
      logic        stop;
      logic [63:0] expected;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Data changes while the clock is high; a glitch is a 3-cycle low pulse mid-high-phase.
   task automatic send_bit(input logic b, input logic glitch);
      ps2_data = b;
      if (glitch) begin
         tick(15);
         ps2_clk = 1'b0;
         tick(3);
         ps2_clk = 1'b1;
         tick(HALF - 18);
      end else begin
         tick(HALF);
      end
      ps2_clk = 1'b0;
      tick(HALF);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_parity,
                             input logic stop, input logic glitch);
      send_bit(1'b0, glitch);
      for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
      send_bit(bad_parity ? ^b : ~^b, glitch);
      send_bit(stop, glitch);
      ps2_data = 1'b1;
      tick(HALF);
   endtask

   task automatic bus_read(input logic [63:0] addr, output logic [63:0] d);
      bus_if.address = addr;
      bus_if.read    = 1'b1;
      tick(1);
      bus_if.read    = 1'b0;
      d = bus_if.data_out;
   endtask

   task automatic bus_write(input logic [63:0] addr, input logic [63:0] wd);
      bus_if.address = addr;
      bus_if.data_in = wd;
      bus_if.write   = 1'b1;
      tick(1);
      bus_if.write   = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [63:0] addr,
                             input logic [63:0] expected);
      logic [63:0] d;
      bus_read(addr, d);
      check_output(name, d, expected);
   endtask

   task automatic apply_stimulus(input vec_t v);
      case (v.op)
         OP_SEND:  send_frame(v.wdata[7:0], v.bad_parity, v.stop, 1'b0);
         OP_WRITE: bus_write(v.addr, v.wdata);
         default:  read_check(v.name, v.addr, v.expected);
      endcase
   endtask

   task automatic add_vec(input op_t op, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic bad_parity, input logic stop,
                          input logic [63:0] expected, input string name);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.bad_parity = bad_parity;
      v.stop = stop; v.expected = expected; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      logic [63:0] d;

      add_vec(OP_READ,  STAT_ADDR, 0,      0, 1, 64'h0,    "reset_status");
      add_vec(OP_READ,  DATA_ADDR, 0,      0, 1, 64'h0,    "reset_empty_data");
      add_vec(OP_SEND,  0,         8'h1C,  0, 1, 0,        "");
      add_vec(OP_READ,  STAT_ADDR, 0,      0, 1, 64'h0101, "status_one_byte");
      add_vec(OP_READ,  DATA_ADDR, 0,      0, 1, 64'h1C,   "data_1c");
      add_vec(OP_READ,  STAT_ADDR, 0,      0, 1, 64'h0,    "status_drained");
      add_vec(OP_SEND,  0,         8'h1C,  1, 1, 0,        "");
      add_vec(OP_SEND,  0,         8'hA5,  0, 0, 0,        "");
      add_vec(OP_READ,  STAT_ADDR, 0,      0, 1, 64'h4,    "status_frame_err");
      add_vec(OP_WRITE, STAT_ADDR, 64'h4,  0, 1, 0,        "");
      add_vec(OP_READ,  STAT_ADDR, 0,      0, 1, 64'h0,    "status_err_cleared");
      add_vec(OP_SEND,  0,         8'h33,  0, 1, 0,        "");
      add_vec(OP_WRITE, DATA_ADDR, 64'hFF, 0, 1, 0,        "");
      add_vec(OP_READ,  64'h31002, 0,      0, 1, 64'h0,    "other_address");
      add_vec(OP_READ,  STAT_ADDR, 0,      0, 1, 64'h0101, "status_after_ignored_ops");
      add_vec(OP_READ,  DATA_ADDR, 0,      0, 1, 64'h33,   "data_33");

      reset          = 1'b1;
      ps2_clk        = 1'b1;
      ps2_data       = 1'b1;
      bus_if.address = '0;
      bus_if.read    = 1'b0;
      bus_if.write   = 1'b0;
      bus_if.data_in = '0;
      tick(3);
      reset = 1'b0;
      tick(2);
      check_output("reset_data_out", bus_if.data_out, 64'h0);

      foreach (vecs[i]) apply_stimulus(vecs[i]);

      // Overflow: 17 frames into a 16-deep FIFO
      for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0);
      read_check("status_full_overflow", STAT_ADDR, 64'h1003);
      for (int i = 0; i < 16; i++) read_check($sformatf("fifo_order_%0d", i), DATA_ADDR, 64'(i));
      read_check("read_after_drain", DATA_ADDR, 64'h0);
      read_check("status_overflow_only", STAT_ADDR, 64'h0002);
      bus_write(STAT_ADDR, 64'h2);
      read_check("status_overflow_cleared", STAT_ADDR, 64'h0);

      // Timeout: start plus four data bits, then the clock stays high
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      ps2_data = 1'b1;
      tick(TIMEOUT + 10);
      read_check("status_timeout", STAT_ADDR, 64'h4);
      send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
      read_check("status_after_timeout_frame", STAT_ADDR, 64'h0105);
      read_check("data_f0", DATA_ADDR, 64'hF0);
      bus_write(STAT_ADDR, 64'h4);
      read_check("status_timeout_cleared", STAT_ADDR, 64'h0);

      // Short low glitches on ps2_clk must not create extra edges
      send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
      read_check("status_glitch_frame", STAT_ADDR, 64'h0101);
      read_check("data_5a", DATA_ADDR, 64'h5A);

      // Full FIFO: data read lands in the same cycle as the stop-bit push
      for (int i = 0; i < 16; i++) send_frame(8'(8'h20 + i), 1'b0, 1'b1, 1'b0);
      read_check("status_full", STAT_ADDR, 64'h1001);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(8'h30 >> i, 1'b0);
      send_bit(~^8'h30, 1'b0);
      ps2_data = 1'b1;
      tick(HALF);
      ps2_clk = 1'b0;
      tick(9);
      bus_if.address = DATA_ADDR;
      bus_if.read    = 1'b1;
      tick(1);
      bus_if.read    = 1'b0;
      d = bus_if.data_out;
      check_output("pop_push_same_cycle_data", d, 64'h20);
      tick(HALF - 10);
      ps2_clk = 1'b1;
      tick(HALF);
      read_check("status_pop_push_full", STAT_ADDR, 64'h1001);
      for (int i = 0; i < 16; i++)
         read_check($sformatf("drain_%0d", i), DATA_ADDR, 64'(8'h21 + i));
      read_check("status_final", STAT_ADDR, 64'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

Memory-mapped PS/2 keyboard receiver; the input-side companion to the text display on the same CPU bus. Deserializes PS/2 device-to-host frames into scan-code bytes and buffers them in a FIFO. The CPU pops bytes with bus reads of a data register and polls a status register. Host-to-device transmission is out of scope.

## Interface
- DATA_ADDRESS, 64'h31000, read pops one scan-code byte
- STATUS_ADDRESS, 64'h31001, status read / sticky-flag clear
- FIFO_DEPTH, 16, byte entries, power of two, 2..256
- FILTER_CYCLES, 8, consecutive equal samples required to accept a ps2_clk level change
- TIMEOUT_CYCLES, 50000, idle clocks mid-frame before abort (1 ms at 50 MHz)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- address  in  64  bus address
- read  in  1  read strobe, one cycle per access
- write  in  1  write strobe
- data_in  in  64  write data
- data_out  out  64  registered read data
- ps2_clk  in  1  asynchronous PS/2 clock pin
- ps2_data  in  1  asynchronous PS/2 data pin

## Operation
- Both pins pass through 2-flop synchronizers. The synchronized ps2_clk then feeds a glitch filter: the filtered level changes only after FILTER_CYCLES consecutive samples of the new level.
- A falling edge of the filtered clock samples synchronized ps2_data.
- Frame format: start(0), 8 data bits LSB first, odd parity, stop(1).
- FSM states and transitions:
  - IDLE: falling edge with data=0 → DATA, bit count 0. Falling edge with data=1 is ignored.
  - DATA: shift the sampled bit into shift[7]. After the 8th bit → PARITY.
  - PARITY: capture the bit → STOP.
  - STOP: if stop=1 and XOR(byte, parity)=1, push the byte; otherwise set frame_err and discard. Either way → IDLE.
- Timeout: in any non-IDLE state, a counter reaching TIMEOUT_CYCLES with no falling edge → IDLE. The frame is discarded and frame_err is set. The counter reloads on every falling edge.
- FIFO push when full: the byte is dropped, the FIFO is unchanged, and overflow is set.
- Data read (read & address==DATA_ADDRESS):
  - Not empty: data_out={56'b0, head}, head pops.
  - Empty: data_out=0, no pop.
- Status read: data_out = {48'b0, count[7:0], 5'b0, frame_err, overflow, not_empty}.
  - count is the occupancy 0..FIFO_DEPTH. With FIFO_DEPTH=256, a full FIFO reads as count 0 with not_empty=1.
- Status write: data_in[1]=1 clears overflow; data_in[2]=1 clears frame_err. Writes to DATA_ADDRESS are ignored.
- Sticky set and clear in the same cycle: set wins.
- Push and pop in the same cycle: both occur and count is unchanged. If the FIFO is full, the pop frees space, so the push is accepted and overflow is not set.
- Push into an empty FIFO while a data read occurs in the same cycle: the read returns 0. The byte becomes visible to the next read.
- Read of any other address: data_out=0.

## Timing
- Reset values:
  - FSM IDLE, FIFO empty, flags 0, data_out 0.
  - Synchronizer and filtered-clock registers reset to 1.
  - Timeout counter 0.
- data_out is valid on the cycle after the read strobe, and holds until the next read.
- Pop takes effect at the same edge that loads data_out.
- Stop-bit falling edge to not_empty=1 is visible in the status read issued on the following cycle.
- Pin-to-sample latency is 2 synchronizer cycles + FILTER_CYCLES. This is negligible against the PS/2 bit period (60–100 µs).
- Reset mid-frame aborts the frame with no flag set. Bytes already in the FIFO are lost.

## Structure
- Package ps2_pkg:
  - FSM state enum: IDLE, DATA, PARITY, STOP.
  - Status bit indices: NOT_EMPTY=0, OVERFLOW=1, FRAME_ERR=2, COUNT_LSB=8.
- Sub-module byte_fifo:
  - Parameter DEPTH.
  - Ports push, din[7:0], pop, dout[7:0], full, empty, count.
  - Head is combinationally visible on dout.
  - Pointer-based with an occupancy counter; pointers wrap modulo DEPTH.
- Top level holds the synchronizers, filter, FSM, timeout counter, flags and bus decode.

## Test plan
- Send byte 8'h1C, parity 0, stop 1. Then read STATUS → 64'h0101. Then read DATA → 64'h1C. Then read STATUS → 0.
- Send 17 valid bytes 8'h00..8'h10 with no reads:
  - STATUS → count 16, overflow 1.
  - 16 DATA reads → 8'h00..8'h0F in order.
  - One further read → 0.
- Send a frame with bad parity, then a frame with stop=0:
  - FIFO stays empty, frame_err=1.
  - Write STATUS data_in=4 → frame_err=0.
- Send start + 4 bits, then leave ps2_clk high for TIMEOUT_CYCLES+10:
  - FSM returns to IDLE, frame_err=1.
  - A following valid 8'hF0 frame is received intact.
- Inject 3-cycle low glitches on ps2_clk with FILTER_CYCLES=8 during a valid 8'h5A frame → byte 8'h5A received, no error.
- With the FIFO full, issue a DATA read in the same cycle the stop bit completes → read returns the oldest byte, the new byte is accepted, count stays 16, overflow stays 0.
